// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C-style target backed by a 256x8 register file.
// Oversamples SCL/SDA on clk, decodes START/STOP/repeated START, accepts
// dev/sub/data writes (with burst auto-increment) and dev/sub + dev reads.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   scl_in, sda_in       asynchronous bus inputs from the pads
//   sda_drive_low        1 = pull SDA low (open-drain at top level)
//   wr_stb/addr/data     1-cycle register-file write notification
//   sub_addr             current register pointer
//   busy                 high from START until STOP
//   addr_err             sticky device-address mismatch flag
//   dbg_addr/dbg_data    registered debug read port, 1-cycle latency
module sccb_target #(
   parameter logic [6:0]  DEV_ADDR    = 7'h21,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_drive_low,
   output logic       wr_stb,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic [7:0] sub_addr,
   output logic       busy,
   output logic       addr_err,
   input  logic [7:0] dbg_addr,
   output logic [7:0] dbg_data
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, RD_BIT, RD_ACK, IGNORE
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   ack_on_q, ack_on_d;
   logic                   rw_q, rw_d;
   logic                   sda_drive_low_q, sda_drive_low_d;
   logic                   wr_stb_q, wr_stb_d;
   logic [7:0]             wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic [7:0]             sub_addr_q, sub_addr_d;
   logic                   busy_q, busy_d;
   logic                   addr_err_q, addr_err_d;
   logic [7:0]             dbg_data_q, dbg_data_d;

   // Not reset: contents survive reset; power-up zeros come from device config.
   logic [7:0] regfile_q [256];

   logic       scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
   logic [7:0] byte_in, sub_inc, rd_idx, rd_word;

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_prev_q;
   assign scl_fall = ~scl_s & scl_prev_q;
   // SDA edges with SCL held high across both samples are bus conditions.
   assign start_c  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
   assign stop_c   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   assign byte_in  = {shift_q[6:0], sda_s};
   assign sub_inc  = sub_addr_q + 8'd1;
   // RD_ACK prefetches the next byte, all other read loads use the pointer.
   assign rd_idx   = (state_q == RD_ACK) ? sub_inc : sub_addr_q;
   assign rd_word  = regfile_q[rd_idx];

   // Synchronizers, edge history and debug port.
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_d = scl_s;
      sda_prev_d = sda_s;
      dbg_data_d = regfile_q[dbg_addr];
   end

   // Protocol next-state and output logic.
   always_comb begin
      state_d         = state_q;
      bit_cnt_d       = bit_cnt_q;
      shift_d         = shift_q;
      ack_on_d        = ack_on_q;
      rw_d            = rw_q;
      sda_drive_low_d = sda_drive_low_q;
      wr_stb_d        = 1'b0;
      wr_addr_d       = wr_addr_q;
      wr_data_d       = wr_data_q;
      sub_addr_d      = sub_addr_q;
      busy_d          = busy_q;
      addr_err_d      = addr_err_q;

      if (start_c) begin
         state_d         = ADDR;
         bit_cnt_d       = CNT_W'(7);
         ack_on_d        = 1'b0;
         sda_drive_low_d = 1'b0;
         busy_d          = 1'b1;
      end else if (stop_c) begin
         state_d         = IDLE;
         ack_on_d        = 1'b0;
         sda_drive_low_d = 1'b0;
         busy_d          = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = byte_in;
               if (bit_cnt_q == '0) begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                     state_d  = ADDR_ACK;
                     rw_d     = byte_in[0];
                     ack_on_d = 1'b0;
                  end else begin
                     state_d    = IGNORE;
                     addr_err_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
               end
            end
            // First fall starts the ACK, second fall ends it; a read presents
            // its MSB on that same second fall.
            ADDR_ACK: if (scl_fall) begin
               if (!ack_on_q) begin
                  ack_on_d        = 1'b1;
                  sda_drive_low_d = 1'b1;
               end else begin
                  ack_on_d  = 1'b0;
                  bit_cnt_d = CNT_W'(7);
                  if (rw_q) begin
                     state_d         = RD_BIT;
                     sda_drive_low_d = ~rd_word[7];
                     shift_d         = {rd_word[6:0], 1'b0};
                  end else begin
                     state_d         = SUB;
                     sda_drive_low_d = 1'b0;
                  end
               end
            end
            SUB: if (scl_rise) begin
               shift_d = byte_in;
               if (bit_cnt_q == '0) begin
                  sub_addr_d = byte_in;
                  state_d    = SUB_ACK;
                  ack_on_d   = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
               end
            end
            SUB_ACK: if (scl_fall) begin
               ack_on_d        = ~ack_on_q;
               sda_drive_low_d = ~ack_on_q;
               if (ack_on_q) begin
                  state_d   = DATA;
                  bit_cnt_d = CNT_W'(7);
               end
            end
            DATA: if (scl_rise) begin
               shift_d = byte_in;
               if (bit_cnt_q == '0) begin
                  wr_stb_d  = 1'b1;
                  wr_addr_d = sub_addr_q;
                  wr_data_d = byte_in;
                  state_d   = DATA_ACK;
                  ack_on_d  = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q - CNT_W'(1);
               end
            end
            DATA_ACK: if (scl_fall) begin
               ack_on_d        = ~ack_on_q;
               sda_drive_low_d = ~ack_on_q;
               if (ack_on_q) begin
                  sub_addr_d = sub_inc;
                  state_d    = DATA;
                  bit_cnt_d  = CNT_W'(7);
               end
            end
            // bit_cnt counts bits still to present; 0 means release for ACK.
            RD_BIT: if (scl_fall) begin
               if (bit_cnt_q == '0) begin
                  sda_drive_low_d = 1'b0;
                  state_d         = RD_ACK;
               end else begin
                  sda_drive_low_d = ~shift_q[7];
                  shift_d         = {shift_q[6:0], 1'b0};
                  bit_cnt_d       = bit_cnt_q - CNT_W'(1);
               end
            end
            RD_ACK: if (scl_rise) begin
               sub_addr_d = sub_inc;
               if (!sda_s) begin
                  shift_d   = rd_word;
                  bit_cnt_d = CNT_W'(8);
                  state_d   = RD_BIT;
               end else begin
                  state_d = IGNORE;
               end
            end
            IDLE, IGNORE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= IDLE;
         scl_sync_q      <= '1;
         sda_sync_q      <= '1;
         scl_prev_q      <= 1'b1;
         sda_prev_q      <= 1'b1;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         ack_on_q        <= 1'b0;
         rw_q            <= 1'b0;
         sda_drive_low_q <= 1'b0;
         wr_stb_q        <= 1'b0;
         wr_addr_q       <= '0;
         wr_data_q       <= '0;
         sub_addr_q      <= '0;
         busy_q          <= 1'b0;
         addr_err_q      <= 1'b0;
         dbg_data_q      <= '0;
      end else begin
         state_q         <= state_d;
         scl_sync_q      <= scl_sync_d;
         sda_sync_q      <= sda_sync_d;
         scl_prev_q      <= scl_prev_d;
         sda_prev_q      <= sda_prev_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         ack_on_q        <= ack_on_d;
         rw_q            <= rw_d;
         sda_drive_low_q <= sda_drive_low_d;
         wr_stb_q        <= wr_stb_d;
         wr_addr_q       <= wr_addr_d;
         wr_data_q       <= wr_data_d;
         sub_addr_q      <= sub_addr_d;
         busy_q          <= busy_d;
         addr_err_q      <= addr_err_d;
         dbg_data_q      <= dbg_data_d;
      end
   end

   // Write lands at the end of the wr_stb cycle, so a same-cycle debug read sees old data.
   always_ff @(posedge clk) begin
      if (wr_stb_q) begin
         regfile_q[wr_addr_q] <= wr_data_q;
      end
   end

   assign sda_drive_low = sda_drive_low_q;
   assign wr_stb        = wr_stb_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign sub_addr      = sub_addr_q;
   assign busy          = busy_q;
   assign addr_err      = addr_err_q;
   assign dbg_data      = dbg_data_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed bench for sccb_target. A bit-banged bus master
// drives SCL/SDA (open-drain wired with the target), a table of write
// transactions is applied in a loop, then hand-written read, burst,
// aborted-write, debug-collision and reset-during-ACK sequences.
module tb_sccb_target;

   logic       clk = 1'b0;
   logic       reset;
   logic       scl_in;
   logic       sda_in;
   logic       sda_drive_low;
   logic       wr_stb;
   logic [7:0] wr_addr, wr_data, sub_addr;
   logic       busy, addr_err;
   logic [7:0] dbg_addr, dbg_data;

   logic        sda_m;
   int unsigned q;

   int n_checks = 0;
   int n_fail   = 0;

   // Bus-side observation, written only here.
   int         wr_cnt  = 0;
   int         drv_cnt = 0;
   logic [7:0] last_addr = 8'h00, last_data = 8'h00;
   logic       stb_n1 = 1'b0, stb_n2 = 1'b0;
   logic [7:0] dbg_after1 = 8'h00, dbg_after2 = 8'h00;

   assign sda_in = sda_m & ~sda_drive_low;

   always #5 clk = ~clk;

   sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
      .sda_drive_low(sda_drive_low), .wr_stb(wr_stb), .wr_addr(wr_addr),
      .wr_data(wr_data), .sub_addr(sub_addr), .busy(busy), .addr_err(addr_err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always @(negedge clk) begin
      stb_n1 <= wr_stb;
      stb_n2 <= stb_n1;
      if (stb_n1) dbg_after1 <= dbg_data;
      if (stb_n2) dbg_after2 <= dbg_data;
      if (wr_stb) begin
         wr_cnt    <= wr_cnt + 1;
         last_addr <= wr_addr;
         last_data <= wr_data;
      end
      if (sda_drive_low) drv_cnt <= drv_cnt + 1;
   end

   task automatic check1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checki(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; tick(q);
      scl_in = 1'b1; tick(2 * q);
      sda_m = 1'b0; tick(2 * q);
      scl_in = 1'b0; tick(q);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(q);
      scl_in = 1'b1; tick(2 * q);
      sda_m = 1'b1; tick(2 * q);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b; tick(q);
      scl_in = 1'b1; tick(2 * q);
      scl_in = 1'b0; tick(q);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; tick(q);
      scl_in = 1'b1; tick(q);
      b = sda_in; tick(q);
      scl_in = 1'b0; tick(q);
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(output logic [7:0] v, input logic nack);
      logic b;
      logic [7:0] t;
      t = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         t[i] = b;
      end
      send_bit(nack);
      v = t;
   endtask

   task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
      dbg_addr = a;
      tick(1);
      d = dbg_data;
   endtask

   typedef struct {
      logic [7:0]  dev;
      logic [7:0]  sub;
      logic [7:0]  data;
      int unsigned qp;
      logic [2:0]  acks;
      int          nwr;
      logic [7:0]  exp_reg;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic       a0, a1, a2, a3, a4;
      logic [7:0] d0, d1, d2;
      int         wr0, drv0;

      tbl[0] = '{8'h42, 8'h12, 8'h80, 250, 3'b111, 1, 8'h80};
      tbl[1] = '{8'h42, 8'h40, 8'h5A, 4,   3'b111, 1, 8'h5A};
      tbl[2] = '{8'h42, 8'h3A, 8'h04, 4,   3'b111, 1, 8'h04};
      tbl[3] = '{8'h60, 8'h40, 8'h77, 4,   3'b000, 0, 8'h5A};
      tbl[4] = '{8'h42, 8'h55, 8'hA5, 4,   3'b111, 1, 8'hA5};

      reset = 1'b1; scl_in = 1'b1; sda_m = 1'b1; dbg_addr = 8'h00; q = 4;
      tick(3);
      check1("rst_sda_drive_low", sda_drive_low, 1'b0);
      check1("rst_wr_stb", wr_stb, 1'b0);
      check8("rst_wr_addr", wr_addr, 8'h00);
      check8("rst_wr_data", wr_data, 8'h00);
      check8("rst_sub_addr", sub_addr, 8'h00);
      check1("rst_busy", busy, 1'b0);
      check1("rst_addr_err", addr_err, 1'b0);
      check8("rst_dbg_data", dbg_data, 8'h00);
      reset = 1'b0;
      tick(5);

      // Table of single-register writes (row 0 at 100 kHz).
      for (int r = 0; r < 5; r++) begin
         q    = tbl[r].qp;
         wr0  = wr_cnt;
         drv0 = drv_cnt;
         bus_start();
         check1($sformatf("row%0d_busy_after_start", r), busy, 1'b1);
         send_byte(tbl[r].dev, a0);
         send_byte(tbl[r].sub, a1);
         send_byte(tbl[r].data, a2);
         bus_stop();
         tick(4);
         check8($sformatf("row%0d_acks", r), {5'b0, a0, a1, a2}, {5'b0, tbl[r].acks});
         check1($sformatf("row%0d_busy_after_stop", r), busy, 1'b0);
         checki($sformatf("row%0d_wr_count", r), wr_cnt - wr0, tbl[r].nwr);
         if (tbl[r].nwr != 0) begin
            check8($sformatf("row%0d_wr_addr", r), last_addr, tbl[r].sub);
            check8($sformatf("row%0d_wr_data", r), last_data, tbl[r].data);
         end
         check1($sformatf("row%0d_drove_sda", r), drv_cnt != drv0, tbl[r].acks[2]);
         dbg_read(tbl[r].sub, d0);
         check8($sformatf("row%0d_dbg_reg", r), d0, tbl[r].exp_reg);
      end
      check1("addr_err_sticky", addr_err, 1'b1);
      q = 4;

      // Set pointer, STOP, then read one byte with master NACK.
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h3A, a1);
      bus_stop();
      bus_start();
      send_byte(8'h43, a2);
      recv_byte(d0, 1'b1);
      bus_stop();
      tick(4);
      check8("rd_acks", {5'b0, a0, a1, a2}, 8'h07);
      check8("rd_data_3a", d0, 8'h04);
      check8("rd_sub_addr_after", sub_addr, 8'h3B);
      check1("rd_sda_released", sda_drive_low, 1'b0);

      // Burst write wrapping the pointer at FF.
      wr0 = wr_cnt;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'hFE, a1);
      send_byte(8'h11, a2);
      send_byte(8'h22, a3);
      send_byte(8'h33, a4);
      bus_stop();
      tick(4);
      check8("burst_acks", {3'b0, a0, a1, a2, a3, a4}, 8'h1F);
      checki("burst_wr_count", wr_cnt - wr0, 3);
      check8("burst_sub_addr", sub_addr, 8'h01);
      dbg_read(8'hFE, d0);
      dbg_read(8'hFF, d1);
      dbg_read(8'h00, d2);
      check8("burst_reg_fe", d0, 8'h11);
      check8("burst_reg_ff", d1, 8'h22);
      check8("burst_reg_00", d2, 8'h33);

      // Burst read across the wrap: ACK, ACK, NACK.
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'hFE, a1);
      bus_stop();
      bus_start();
      send_byte(8'h43, a2);
      recv_byte(d0, 1'b0);
      recv_byte(d1, 1'b0);
      recv_byte(d2, 1'b1);
      bus_stop();
      tick(4);
      check8("brd_acks", {5'b0, a0, a1, a2}, 8'h07);
      check8("brd_byte0", d0, 8'h11);
      check8("brd_byte1", d1, 8'h22);
      check8("brd_byte2", d2, 8'h33);
      check8("brd_sub_addr", sub_addr, 8'h01);

      // STOP after 4 data bits of D0 to reg 40: nothing written.
      wr0 = wr_cnt;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h40, a1);
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      bus_stop();
      tick(4);
      checki("abort_wr_count", wr_cnt - wr0, 0);
      check1("abort_busy", busy, 1'b0);
      check1("abort_sda_released", sda_drive_low, 1'b0);
      check8("abort_sub_addr", sub_addr, 8'h40);
      dbg_read(8'h40, d0);
      check8("abort_reg_40", d0, 8'h5A);

      // Debug port parked on 40 while it is rewritten: old value, then new.
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h40, a1);
      send_byte(8'hC3, a2);
      bus_stop();
      tick(4);
      check8("coll_dbg_old", dbg_after1, 8'h5A);
      check8("coll_dbg_new", dbg_after2, 8'hC3);
      check8("coll_dbg_now", dbg_data, 8'hC3);

      // Reset while the address ACK is being driven.
      bus_start();
      for (int i = 7; i >= 0; i--) send_bit(8'h42 >> i);
      check1("t6_ack_driven", sda_drive_low, 1'b1);
      reset = 1'b1;
      tick(1);
      check1("t6_sda_released", sda_drive_low, 1'b0);
      check1("t6_busy", busy, 1'b0);
      check8("t6_sub_addr", sub_addr, 8'h00);
      check1("t6_addr_err_cleared", addr_err, 1'b0);
      reset = 1'b0; scl_in = 1'b1; sda_m = 1'b1;
      tick(8);
      wr0 = wr_cnt;
      bus_start();
      send_byte(8'h42, a0);
      send_byte(8'h12, a1);
      send_byte(8'h14, a2);
      bus_stop();
      tick(4);
      check8("t6_acks", {5'b0, a0, a1, a2}, 8'h07);
      checki("t6_wr_count", wr_cnt - wr0, 1);
      dbg_read(8'h12, d0);
      check8("t6_reg_12", d0, 8'h14);
      dbg_read(8'h40, d1);
      check8("t6_reg_40_kept", d1, 8'hC3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
